// File: rtl/hex_line_formatter_if.sv
// Ringbuffer-read and uart_tx byte-strobe signals of the hex line formatter.
// master = the formatter, slave = the ringbuffer/uart_tx side.
interface hex_line_formatter_if #(
  parameter int DW = 48
);
  logic          read_empty;
  logic          read_clock_enable;
  logic [DW-1:0] read_data;
  logic          overflow;
  logic          uart_ready;
  logic          uart_clock_enable;
  logic [7:0]    uart_data;

  modport master (
    input  read_empty, read_data, overflow, uart_ready,
    output read_clock_enable, uart_clock_enable, uart_data
  );

  modport slave (
    output read_empty, read_data, overflow, uart_ready,
    input  read_clock_enable, uart_clock_enable, uart_data
  );
endinterface

// File: rtl/hex_line_formatter.sv
// Pops one record, prints it as uppercase hex plus line end (or an "OVF" line) one byte per strobe.
// 3 cycles from pop decision to first byte; >=2 cycles per byte, stalls indefinitely while uart_ready=0.
module hex_line_formatter #(
  parameter int DW            = 48,
  parameter bit LINE_END_CRLF = 1'b1
) (
  input logic           clock,
  input logic           reset,
  hex_line_formatter_if.master bus
);
  localparam int NIB = DW / 4;
  // The OVF line needs indices up to 4, so the counter is never narrower than 3 bits
  localparam int IW = ($clog2(NIB + 2) < 3) ? 3 : $clog2(NIB + 2);

  localparam logic [IW-1:0] NIB_IDX  = IW'(NIB);
  localparam logic [IW-1:0] LAST_HEX = IW'(LINE_END_CRLF ? NIB + 1 : NIB);
  localparam logic [IW-1:0] LAST_OVF = IW'(LINE_END_CRLF ? 4 : 3);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [DW-1:0] record;
  logic          mode_ovf;
  logic          ovf_pending;
  logic          overflow_d;

  logic [3:0]    nib;
  logic [7:0]    char_byte;
  logic [IW-1:0] last_idx;
  logic          ovf_rise;
  logic          send_now;
  logic          ovf_clear;

  assign ovf_rise  = bus.overflow & ~overflow_d;
  assign send_now  = (state == ST_SEND) && bus.uart_ready;
  assign ovf_clear = send_now && mode_ovf && (idx == '0);
  assign last_idx  = mode_ovf ? LAST_OVF : LAST_HEX;

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) nib = record[DW-1-4*i -: 4];
    end
  end

  always_comb begin
    char_byte = 8'h0A;
    if (mode_ovf) begin
      if (idx == IW'(0))                        char_byte = 8'h4F;
      else if (idx == IW'(1))                   char_byte = 8'h56;
      else if (idx == IW'(2))                   char_byte = 8'h46;
      else if (LINE_END_CRLF && idx == IW'(3))  char_byte = 8'h0D;
      else                                      char_byte = 8'h0A;
    end else if (idx < NIB_IDX) begin
      char_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (LINE_END_CRLF && idx == NIB_IDX) begin
      char_byte = 8'h0D;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      idx                   <= '0;
      record                <= '0;
      mode_ovf              <= 1'b0;
      ovf_pending           <= 1'b0;
      overflow_d            <= 1'b0;
      bus.read_clock_enable <= 1'b0;
      bus.uart_clock_enable <= 1'b0;
      bus.uart_data         <= 8'h00;
    end else begin
      overflow_d            <= bus.overflow;
      // a new rising edge on the clearing cycle keeps the flag set
      ovf_pending           <= ovf_rise | (ovf_pending & ~ovf_clear);
      bus.read_clock_enable <= 1'b0;
      bus.uart_clock_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ovf_pending) begin
            mode_ovf <= 1'b1;
            idx      <= '0;
            state    <= ST_SEND;
          end else if (!bus.read_empty) begin
            bus.read_clock_enable <= 1'b1;
            state                 <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          record   <= bus.read_data;
          mode_ovf <= 1'b0;
          idx      <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.uart_ready) begin
            bus.uart_data         <= char_byte;
            bus.uart_clock_enable <= 1'b1;
            state                 <= ST_GUARD;
          end
        end
        // uart_ready may still be stale here, so this cycle never sends
        ST_GUARD: begin
          if (idx == last_idx) begin
            idx   <= '0;
            state <= ST_IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_SEND;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_line_formatter.sv
// Directed bench: ringbuffer and uart models around a CRLF and an LF-only formatter instance.
module tb_hex_line_formatter;
  logic clock;
  logic reset;

  hex_line_formatter_if #(.DW(48)) bus ();
  hex_line_formatter_if #(.DW(48)) bus_lf ();

  hex_line_formatter #(.DW(48), .LINE_END_CRLF(1'b1)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  hex_line_formatter #(.DW(48), .LINE_END_CRLF(1'b0)) u_dut_lf (
    .clock (clock),
    .reset (reset),
    .bus   (bus_lf)
  );

  typedef struct {
    logic [47:0] rec;
    logic [95:0] hex;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops     = 0;
  int pops_lf  = 0;
  int dbl      = 0;

  logic [47:0] rb_q[$];
  logic [47:0] rb_lf[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  rx_lf[$];
  int          strobe_cyc[$];
  int          pop_cyc[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Ringbuffer model: data appears the cycle after the pop strobe
  initial begin
    logic [47:0] pend;
    bus.read_empty = 1'b1;
    bus.read_data  = '0;
    forever begin
      @(negedge clock);
      if (bus.read_clock_enable === 1'b1) begin
        pops++;
        pop_cyc.push_back(cyc);
        pend = '0;
        if (rb_q.size() > 0) pend = rb_q.pop_front();
        bus.read_empty = (rb_q.size() == 0);
        @(posedge clock);
        #1 bus.read_data = pend;
      end else begin
        bus.read_empty = (rb_q.size() == 0);
      end
    end
  end

  initial begin
    logic [47:0] pend;
    bus_lf.read_empty = 1'b1;
    bus_lf.read_data  = '0;
    forever begin
      @(negedge clock);
      if (bus_lf.read_clock_enable === 1'b1) begin
        pops_lf++;
        pend = '0;
        if (rb_lf.size() > 0) pend = rb_lf.pop_front();
        bus_lf.read_empty = (rb_lf.size() == 0);
        @(posedge clock);
        #1 bus_lf.read_data = pend;
      end else begin
        bus_lf.read_empty = (rb_lf.size() == 0);
      end
    end
  end

  // uart_tx side monitors
  initial begin
    logic prev_uce;
    prev_uce = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.uart_clock_enable === 1'b1) begin
        rx_q.push_back(bus.uart_data);
        strobe_cyc.push_back(cyc);
        if (prev_uce) dbl++;
      end
      if (bus_lf.uart_clock_enable === 1'b1) rx_lf.push_back(bus_lf.uart_data);
      prev_uce = (bus.uart_clock_enable === 1'b1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hEE;
  endfunction

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clock);
      #1;
      c++;
    end
    chk($sformatf("wait_bytes_%0d", n), 64'(rx_q.size() >= n), 64'd1);
  endtask

  task automatic settle();
    repeat (6) @(negedge clock);
    #1;
  endtask

  task automatic clear_logs();
    rx_q.delete();
    strobe_cyc.delete();
    pop_cyc.delete();
  endtask

  task automatic check_line(input string tag, input int base, input logic [95:0] hex);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s_c%0d", tag, i), 64'(rx_at(base + i)), 64'(hex[95-8*i -: 8]));
    chk({tag, "_cr"}, 64'(rx_at(base + 12)), 64'h0D);
    chk({tag, "_lf"}, 64'(rx_at(base + 13)), 64'h0A);
  endtask

  task automatic check_ovf(input string tag, input int base);
    logic [39:0] ov;
    ov = 40'h4F56460D0A;
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_o%0d", tag, i), 64'(rx_at(base + i)), 64'(ov[39-8*i -: 8]));
  endtask

  initial begin
    vec_t        vecs[4];
    int          p0;
    int          n_cr;
    logic [95:0] lf_hex;

    vecs[0] = '{48'h12345678AB03, "12345678AB03"};
    vecs[1] = '{48'h9ABCDEF01234, "9ABCDEF01234"};
    vecs[2] = '{48'h000000000000, "000000000000"};
    vecs[3] = '{48'hFFFFFFFFFFFF, "FFFFFFFFFFFF"};
    lf_hex  = "A5A5A5A5A5A5";

    reset             = 1'b1;
    bus.overflow      = 1'b0;
    bus.uart_ready    = 1'b1;
    bus_lf.overflow   = 1'b0;
    bus_lf.uart_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_rce", 64'(bus.read_clock_enable), 64'd0);
    chk("rst_uce", 64'(bus.uart_clock_enable), 64'd0);
    chk("rst_data", 64'(bus.uart_data), 64'h00);
    chk("rst_lf_uce", 64'(bus_lf.uart_clock_enable), 64'd0);
    reset = 1'b0;

    // Empty ringbuffer: nothing happens
    clear_logs();
    p0 = pops;
    repeat (100) @(negedge clock);
    #1;
    chk("idle_pops", 64'(pops - p0), 64'd0);
    chk("idle_bytes", 64'(rx_q.size()), 64'd0);

    for (int v = 0; v < 4; v++) begin
      clear_logs();
      p0 = pops;
      rb_q.push_back(vecs[v].rec);
      wait_bytes(14, 200);
      settle();
      chk($sformatf("vec%0d_pops", v), 64'(pops - p0), 64'd1);
      chk($sformatf("vec%0d_len", v), 64'(rx_q.size()), 64'd14);
      check_line($sformatf("vec%0d", v), 0, vecs[v].hex);
      if (v == 0 && pop_cyc.size() > 0 && strobe_cyc.size() > 1) begin
        chk("latency", 64'(strobe_cyc[0] - pop_cyc[0]), 64'd3);
        chk("spacing", 64'(strobe_cyc[1] - strobe_cyc[0]), 64'd2);
      end
    end

    // Back-to-back records: second pop only after the first LF
    clear_logs();
    p0 = pops;
    rb_q.push_back(48'h000000000000);
    rb_q.push_back(48'hFFFFFFFFFFFF);
    wait_bytes(28, 400);
    settle();
    chk("b2b_pops", 64'(pops - p0), 64'd2);
    chk("b2b_len", 64'(rx_q.size()), 64'd28);
    check_line("b2b_a", 0, vecs[2].hex);
    check_line("b2b_b", 14, vecs[3].hex);
    if (pop_cyc.size() > 1 && strobe_cyc.size() > 13)
      chk("b2b_pop_after_lf", 64'(pop_cyc[1] > strobe_cyc[13]), 64'd1);

    // uart_ready held low before the 5th byte
    clear_logs();
    rb_q.push_back(vecs[0].rec);
    wait_bytes(4, 200);
    bus.uart_ready = 1'b0;
    repeat (50) @(negedge clock);
    #1;
    chk("stall_count", 64'(rx_q.size()), 64'd4);
    chk("stall_hold", 64'(bus.uart_data), 64'h34);
    bus.uart_ready = 1'b1;
    wait_bytes(14, 200);
    settle();
    chk("stall_len", 64'(rx_q.size()), 64'd14);
    check_line("stall", 0, vecs[0].hex);

    // Overflow during a line with one record queued behind it
    clear_logs();
    p0 = pops;
    rb_q.push_back(vecs[0].rec);
    rb_q.push_back(vecs[3].rec);
    wait_bytes(3, 200);
    bus.overflow = 1'b1;
    repeat (4) @(negedge clock);
    bus.overflow = 1'b0;
    wait_bytes(33, 400);
    settle();
    chk("ovf_len", 64'(rx_q.size()), 64'd33);
    chk("ovf_pops", 64'(pops - p0), 64'd2);
    check_line("ovf_a", 0, vecs[0].hex);
    check_ovf("ovf_line", 14);
    check_line("ovf_b", 19, vecs[3].hex);

    // Reset mid-line: the popped record is dropped, the queued one prints in full
    clear_logs();
    rb_q.push_back(vecs[1].rec);
    rb_q.push_back(vecs[0].rec);
    wait_bytes(6, 200);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("mid_rst_uce", 64'(bus.uart_clock_enable), 64'd0);
    chk("mid_rst_rce", 64'(bus.read_clock_enable), 64'd0);
    chk("mid_rst_data", 64'(bus.uart_data), 64'h00);
    repeat (3) @(negedge clock);
    #1;
    chk("mid_rst_quiet", 64'(rx_q.size()), 64'd6);
    reset = 1'b0;
    wait_bytes(20, 300);
    settle();
    chk("mid_rst_len", 64'(rx_q.size()), 64'd20);
    check_line("mid_rst_b", 6, vecs[0].hex);

    // LF-only instance
    rx_lf.delete();
    p0 = pops_lf;
    rb_lf.push_back(48'hA5A5A5A5A5A5);
    for (int c = 0; c < 200 && rx_lf.size() < 13; c++) begin
      @(negedge clock);
      #1;
    end
    settle();
    chk("lf_len", 64'(rx_lf.size()), 64'd13);
    chk("lf_pops", 64'(pops_lf - p0), 64'd1);
    n_cr = 0;
    for (int i = 0; i < rx_lf.size(); i++) begin
      if (rx_lf[i] == 8'h0D) n_cr++;
      if (i < 12) chk($sformatf("lf_c%0d", i), 64'(rx_lf[i]), 64'(lf_hex[95-8*i -: 8]));
    end
    if (rx_lf.size() > 0) chk("lf_end", 64'(rx_lf[rx_lf.size()-1]), 64'h0A);
    chk("lf_no_cr", 64'(n_cr), 64'd0);

    chk("no_double_strobe", 64'(dbl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hex_line_formatter.md
Name: hex_line_formatter

Overview:
- Downstream of the ringbuffer, upstream of uart_tx, in the ext_clock domain.
- Pops one DW-bit LPC record from the ringbuffer and converts it to uppercase ASCII hex, MSB nibble first, terminated by a line ending.
- Drives uart_tx one byte at a time, so the sniffer output is readable in a plain terminal.
- Also emits an "OVF" line whenever a ringbuffer overflow has occurred since the last record.

Parameters:
- DW, 48, record width in bits; must be a multiple of 4; NIB = DW/4 hex characters per record.
- LINE_END_CRLF, 1, 1 = terminate lines with CR LF (0x0D 0x0A); 0 = LF only.

Ports:
- clock  input  1  ext_clock domain clock.
- reset  input  1  asynchronous, active-high reset.
- read_empty  input  1  ringbuffer empty flag.
- read_clock_enable  output  1  one-cycle pop strobe to the ringbuffer.
- read_data  input  DW  ringbuffer output word; valid the cycle after the pop strobe.
- overflow  input  1  ringbuffer overflow level.
- uart_ready  input  1  uart_tx idle and able to accept a byte.
- uart_clock_enable  output  1  one-cycle byte strobe to uart_tx.
- uart_data  output  8  byte to transmit; stable while uart_clock_enable is high.

Behaviour:
- Reset (asynchronous) values:
  - read_clock_enable=0, uart_clock_enable=0, uart_data=0x00.
  - FSM in IDLE, char index=0, record register=0, ovf_pending=0, overflow_d=0.
- Overflow tracking:
  - overflow_d registers overflow every cycle.
  - ovf_pending sets on a rising edge (overflow & ~overflow_d).
  - ovf_pending clears only when the 'O' of an OVF line is strobed.
  - A rising edge on the same cycle as that clear wins: ovf_pending stays 1.
- FSM states: IDLE, FETCH, LOAD, SEND, GUARD.
- IDLE:
  - If ovf_pending, select OVF mode and go to SEND with idx=0. Line is "OVF" + line end.
  - Else if !read_empty: assert read_clock_enable for exactly one cycle and go to FETCH.
  - Else stay in IDLE.
  - OVF has priority over a pending record.
- FETCH: wait one cycle (RAM read latency); go to LOAD.
- LOAD: capture read_data into the record register, select HEX mode, idx=0, go to SEND.
- SEND:
  - Wait while uart_ready=0.
  - When uart_ready=1: drive uart_data=char(idx), pulse uart_clock_enable for one cycle, go to GUARD.
- GUARD:
  - One mandatory cycle that ignores uart_ready. uart_tx drops ready no later than the cycle after a strobe.
  - Then: if idx was the last character, go to IDLE; else idx+1 and go to SEND.
- HEX mode characters:
  - idx 0..NIB-1: nibble record[DW-1-4*idx -: 4]. 0-9 map to 0x30-0x39, A-F to 0x41-0x46.
  - Then line end: CR LF if LINE_END_CRLF, else LF.
  - Line length is NIB+2 bytes (NIB+1 with LF only); 14 bytes for DW=48, CRLF.
- OVF mode characters: 'O' 'V' 'F' followed by the line end.
- Ordering and throughput:
  - Exactly one pop per HEX line; no pop while a line is in progress.
  - read_empty is sampled only in IDLE.
- Latencies:
  - IDLE with data to first uart_clock_enable: 3 cycles when uart_ready is already 1.
  - Minimum byte spacing: 2 cycles, gated by uart_ready.
- Stalls: uart_ready held low stalls indefinitely in SEND. No byte is dropped or duplicated, and uart_data holds its value.
- Reset mid-line: the line is abandoned with no further bytes. A record already popped is lost; this is intentional.
- Index counter: ceil(log2(NIB+2)) bits; it never exceeds the last character index.

Test Plan:
- Ringbuffer holds 0x12345678AB03, uart_ready=1 -> one pop strobe, then 14 strobes with bytes "12345678AB03" 0x0D 0x0A; back to IDLE.
- read_empty=1 for 100 cycles -> no read_clock_enable, no uart_clock_enable.
- Two records 0x000000000000 and 0xFFFFFFFFFFFF back-to-back -> "000000000000\r\n" then "FFFFFFFFFFFF\r\n"; exactly 2 pops; the second pop occurs only after the first LF.
- uart_ready low for 50 cycles before byte 5 -> no strobe during the stall; byte 5 is sent once afterwards with the correct value; total 14 bytes.
- overflow rises while a line is in progress, with one record still queued -> current line completes, then "OVF\r\n", then the queued record's line.
- Reset asserted after byte 6 -> outputs go to 0 immediately. After release, the next queued record is printed in full.
- LINE_END_CRLF=0, record 0xA5A5A5A5A5A5 -> 13 bytes ending in 0x0A, with no 0x0D.
